// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic             w_mainValid;
  logic [WIDTH-1:0] w_mainData;
  logic [CNT_W-1:0] r_stallCnt;

  // Bubbles are forced to zero so downstream decodes a NOP control word.
  assign out_valid = w_mainValid;
  assign out_data  = w_mainValid ? w_mainData : '0;
  assign stall_cnt = r_stallCnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stallCnt <= '0;
    end else if (stall_clr) begin
      r_stallCnt <= '0;
    end else if (w_mainValid && !out_ready && (r_stallCnt != '1)) begin
      r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      state_t           r_state;
      state_t           w_nextState;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic             r_inReady;
      logic             w_accept;
      logic             w_fire;
      logic             w_loadMain;
      logic             w_loadSkid;
      logic             w_mainFromSkid;

      assign w_accept    = in_valid && r_inReady;
      assign w_fire      = (r_state != EMPTY) && out_ready;
      assign in_ready    = r_inReady;
      assign w_mainValid = (r_state != EMPTY);
      assign w_mainData  = r_main;

      always_comb begin
        w_nextState    = r_state;
        w_loadMain     = 1'b0;
        w_loadSkid     = 1'b0;
        w_mainFromSkid = 1'b0;
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              w_loadMain  = 1'b1;
              w_nextState = BUSY;
            end
          end
          BUSY: begin
            if (w_accept && w_fire) begin
              w_loadMain = 1'b1;
            end else if (w_accept) begin
              w_loadSkid  = 1'b1;
              w_nextState = FULL;
            end else if (w_fire) begin
              w_nextState = EMPTY;
            end
          end
          FULL: begin
            if (w_fire) begin
              w_mainFromSkid = 1'b1;
              w_nextState    = BUSY;
            end
          end
          default: w_nextState = EMPTY;
        endcase
        if (flush) begin
          w_nextState = EMPTY;
        end
      end

      // in_ready is registered from the next state so it never sees out_ready.
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          r_state   <= EMPTY;
          r_main    <= '0;
          r_skid    <= '0;
          r_inReady <= 1'b1;
        end else begin
          r_state   <= w_nextState;
          r_inReady <= (w_nextState != FULL);
          if (w_loadMain) begin
            r_main <= in_data;
          end else if (w_mainFromSkid) begin
            r_main <= r_skid;
          end
          if (w_loadSkid) begin
            r_skid <= in_data;
          end
        end
      end
    end else begin : g_single
      logic             r_valid;
      logic [WIDTH-1:0] r_main;
      logic             w_accept;
      logic             w_fire;

      assign in_ready    = !r_valid || out_ready;
      assign w_accept    = in_valid && in_ready;
      assign w_fire      = r_valid && out_ready;
      assign w_mainValid = r_valid;
      assign w_mainData  = r_main;

      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          r_valid <= 1'b0;
          r_main  <= '0;
        end else if (w_accept) begin
          r_valid <= 1'b1;
          r_main  <= in_data;
        end else if (w_fire) begin
          r_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives three pipe_stage_buf variants (SKID=1, SKID=0, SKID=1 with CNT_W=4)
// with shared inputs and compares them against a small FIFO model.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [31:0] inData;
  logic        flush;
  logic        outReady;
  logic        stallClr;

  logic        ov0, ov1, ov2, ir0, ir1, ir2;
  logic [31:0] od0, od1, od2;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  logic        ovA [3];
  logic        irA [3];
  logic [31:0] odA [3];
  logic [15:0] scA [3];

  int nChecks = 0;
  int nErrors = 0;

  // Model: FIFO contents per instance, registered ready, stall count.
  logic [31:0] mBuf  [3][2];
  int          mSize [3];
  bit          mRdy  [3];
  int unsigned mCnt  [3];

  always #5 clk = ~clk;

  always_comb begin
    ovA[0] = ov0; ovA[1] = ov1; ovA[2] = ov2;
    irA[0] = ir0; irA[1] = ir1; irA[2] = ir2;
    odA[0] = od0; odA[1] = od1; odA[2] = od2;
    scA[0] = sc0; scA[1] = sc1; scA[2] = {12'd0, sc2};
  end

  pipe_stage_buf #(.WIDTH(32), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir0), .in_data(inData),
    .flush(flush), .out_valid(ov0), .out_ready(outReady), .out_data(od0),
    .stall_cnt(sc0), .stall_clr(stallClr));

  pipe_stage_buf #(.WIDTH(32), .SKID(0), .CNT_W(16)) dutNoSkid (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir1), .in_data(inData),
    .flush(flush), .out_valid(ov1), .out_ready(outReady), .out_data(od1),
    .stall_cnt(sc1), .stall_clr(stallClr));

  pipe_stage_buf #(.WIDTH(32), .SKID(1), .CNT_W(4)) dutCnt4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ir2), .in_data(inData),
    .flush(flush), .out_valid(ov2), .out_ready(outReady), .out_data(od2),
    .stall_cnt(sc2), .stall_clr(stallClr));

  function automatic logic [31:0] expData(input int k);
    return (mSize[k] > 0) ? mBuf[k][0] : 32'd0;
  endfunction

  function automatic logic expReady(input int k);
    if (k != 1) return mRdy[k];
    return (mSize[k] == 0) || outReady;
  endfunction

  task automatic drive(input bit iv, input logic [31:0] d, input bit orr,
                       input bit fl = 0, input bit clr = 0, input bit rs = 1);
    inValid  = iv;
    inData   = d;
    outReady = orr;
    flush    = fl;
    stallClr = clr;
    rst      = rs;
    @(negedge clk);
  endtask

  task automatic tick();
    bit          v, rdy, fire, acc;
    int unsigned cmax;
    int          cap;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      cmax = (k == 2) ? 15 : 65535;
      cap  = (k == 1) ? 1 : 2;
      if (!rst) begin
        mSize[k] = 0;
        mCnt[k]  = 0;
        mRdy[k]  = 1'b1;
      end else begin
        v    = mSize[k] > 0;
        rdy  = expReady(k);
        fire = v && outReady;
        acc  = inValid && rdy;
        if (stallClr) mCnt[k] = 0;
        else if (v && !outReady && mCnt[k] < cmax) mCnt[k]++;
        if (flush) begin
          mSize[k] = 0;
        end else begin
          if (fire) begin
            mBuf[k][0] = mBuf[k][1];
            mSize[k]--;
          end
          if (acc && mSize[k] < cap) begin
            mBuf[k][mSize[k]] = inData;
            mSize[k]++;
          end
        end
        mRdy[k] = mSize[k] < 2;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 32'hDEADBEEF, 0, 0, 0, 0); tick();
    drive(1, 32'hDEADBEEF, 0, 0, 0, 0); tick();
    drive(0, 32'd0, 0);
    for (int k = 0; k < 3; k++) begin
      nChecks += 4;
      if (ovA[k] !== 1'b0) begin nErrors++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", k, ovA[k]); end
      if (odA[k] !== 32'd0) begin nErrors++; $display("FAIL reset_out_data[%0d] got=%h exp=0", k, odA[k]); end
      if (irA[k] !== 1'b1) begin nErrors++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", k, irA[k]); end
      if (scA[k] !== 16'd0) begin nErrors++; $display("FAIL reset_stall_cnt[%0d] got=%0d exp=0", k, scA[k]); end
    end
    tick();
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i + 1), 1);
      for (int k = 0; k < 2; k++) begin
        nChecks += 2;
        if (irA[k] !== 1'b1) begin nErrors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", k, irA[k]); end
        if (i > 0 && (ovA[k] !== 1'b1 || odA[k] !== 32'(i))) begin
          nErrors++; $display("FAIL stream_out[%0d] got=%b/%0d exp=1/%0d", k, ovA[k], odA[k], i);
        end
      end
      tick();
    end
    drive(0, 32'd0, 1);
    for (int k = 0; k < 2; k++) begin
      nChecks++;
      if (ovA[k] !== 1'b1 || odA[k] !== 32'd4) begin
        nErrors++; $display("FAIL stream_last[%0d] got=%b/%0d exp=1/4", k, ovA[k], odA[k]);
      end
    end
    tick();
    drive(0, 32'd0, 1); tick();
  endtask

  task automatic test_backpressure();
    drive(0, 32'd0, 1, 0, 1); tick();
    drive(1, 32'd5, 0);
    nChecks++;
    if (ir0 !== 1'b1) begin nErrors++; $display("FAIL bp_ready_a got=%b exp=1", ir0); end
    tick();
    drive(1, 32'd6, 0);
    nChecks++;
    if (ir0 !== 1'b1 || od0 !== 32'd5) begin nErrors++; $display("FAIL bp_accept_b got=%b/%0d exp=1/5", ir0, od0); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'd7, 0);
      nChecks++;
      if (ir0 !== 1'b0 || od0 !== 32'd5) begin nErrors++; $display("FAIL bp_full got=%b/%0d exp=0/5", ir0, od0); end
      tick();
    end
    drive(1, 32'd7, 1);
    nChecks++;
    if (sc0 !== 16'd3 || od0 !== 32'd5 || ir0 !== 1'b0) begin
      nErrors++; $display("FAIL bp_stall cnt=%0d data=%0d rdy=%b exp=3/5/0", sc0, od0, ir0);
    end
    tick();
    drive(0, 32'd0, 1);
    nChecks++;
    if (od0 !== 32'd6 || ir0 !== 1'b1) begin nErrors++; $display("FAIL bp_second got=%0d/%b exp=6/1", od0, ir0); end
    tick();
    drive(0, 32'd0, 1);
    nChecks++;
    if (ov0 !== 1'b0) begin nErrors++; $display("FAIL bp_no_third got=%b exp=0", ov0); end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 32'd7, 0); tick();
    drive(1, 32'd8, 0); tick();
    drive(1, 32'd9, 0, 1);
    nChecks++;
    if (ir0 !== 1'b0 || od0 !== 32'd7) begin nErrors++; $display("FAIL flush_pre got=%b/%0d exp=0/7", ir0, od0); end
    tick();
    drive(0, 32'd0, 1);
    nChecks++;
    if (ov0 !== 1'b0 || od0 !== 32'd0 || ir0 !== 1'b1) begin
      nErrors++; $display("FAIL flush_post got=%b/%0d/%b exp=0/0/1", ov0, od0, ir0);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'd0, 1);
      nChecks++;
      if (ov0 !== 1'b0) begin nErrors++; $display("FAIL flush_leak got=%b data=%0d exp=0", ov0, od0); end
      tick();
    end
  endtask

  task automatic test_saturation();
    drive(1, 32'hA, 0, 0, 1); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 32'd0, 0); tick();
    end
    drive(0, 32'd0, 0, 0, 1);
    nChecks++;
    if (sc2 !== 4'd15) begin nErrors++; $display("FAIL sat_value got=%0d exp=15", sc2); end
    tick();
    drive(0, 32'd0, 0);
    nChecks++;
    if (sc2 !== 4'd0) begin nErrors++; $display("FAIL sat_clear got=%0d exp=0", sc2); end
    tick();
    drive(0, 32'd0, 1);
    nChecks++;
    if (sc2 !== 4'd1) begin nErrors++; $display("FAIL sat_recount got=%0d exp=1", sc2); end
    tick();
    drive(0, 32'd0, 1); tick();
  endtask

  task automatic test_no_skid();
    drive(0, 32'd0, 1); tick();
    drive(1, 32'd3, 0);
    nChecks++;
    if (ir1 !== 1'b1) begin nErrors++; $display("FAIL noskid_empty_ready got=%b exp=1", ir1); end
    tick();
    drive(0, 32'd0, 0);
    nChecks++;
    if (ir1 !== 1'b0 || od1 !== 32'd3) begin nErrors++; $display("FAIL noskid_hold got=%b/%0d exp=0/3", ir1, od1); end
    tick();
    drive(1, 32'd4, 1);
    nChecks++;
    if (ir1 !== 1'b1) begin nErrors++; $display("FAIL noskid_comb_ready got=%b exp=1", ir1); end
    tick();
    drive(0, 32'd0, 1);
    nChecks++;
    if (ov1 !== 1'b1 || od1 !== 32'd4) begin nErrors++; $display("FAIL noskid_next got=%b/%0d exp=1/4", ov1, od1); end
    tick();
  endtask

  task automatic test_random();
    bit iv, orr, fl, clr, rs;
    for (int c = 0; c < 600; c++) begin
      iv  = ($urandom % 4) != 0;
      orr = ($urandom % 3) != 0;
      fl  = ($urandom % 25) == 0;
      clr = ($urandom % 40) == 0;
      rs  = ($urandom % 120) != 0;
      drive(iv, $urandom, orr, fl, clr, rs);
      for (int k = 0; k < 3; k++) begin
        nChecks++;
        if (ovA[k] !== (mSize[k] > 0) || odA[k] !== expData(k) ||
            irA[k] !== expReady(k) || scA[k] !== 16'(mCnt[k])) begin
          nErrors++;
          $display("FAIL random[%0d] cyc=%0d got v=%b d=%h r=%b c=%0d exp v=%b d=%h r=%b c=%0d",
                   k, c, ovA[k], odA[k], irA[k], scA[k],
                   mSize[k] > 0, expData(k), expReady(k), mCnt[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mSize[k] = 0; mCnt[k] = 0; mRdy[k] = 1'b1;
      mBuf[k][0] = '0; mBuf[k][1] = '0;
    end
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_no_skid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
